// File: rtl/mips_regfile_mp_pkg.sv
// Shared types and helpers for the multi-read-port MIPS register file.
// Holds the clear-sequencer state encoding, the zero-register index and the address-width helper.
package regfile_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam int REG_ZERO = 0;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mips_regfile_mp_if.sv
// Register-file access bundle: WB write port, N packed read ports, clear request and ready flag.
// master drives writes/read indices; slave (the file) returns ready and combinational read data.
interface mips_regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     clr_req;
  logic                     ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_addr,
    input  ready, rd_data
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_addr,
    output ready, rd_data
  );
endinterface

// File: rtl/mips_regfile_mp_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clr_req, one entry per clock.
// DEPTH cycles per sweep; ready is low for the whole sweep and a new clr_req restarts it from entry 0.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:   ;
      default:  state_d = ST_CLEAR;
    endcase
    // A request in either state restarts the sweep from entry 0.
    if (clr_req) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end
  end

  assign ready = (state_q == ST_RUN);

endmodule

// File: rtl/mips_regfile_mp.sv
// N-read/1-write MIPS register file with optional zero register and sequenced clear; reads are combinational.
// Optional same-cycle write->read forwarding is enabled by defining REGFILE_BYPASS_EN.
module mips_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst_n,
  mips_regfile_mp_if.slave  bus
);

  localparam int                ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] ZADDR  = ADDR_W'(REG_ZERO);
  localparam bit                HAS_Z  = (ZERO_REG != 0);

  reg [DATA_W-1:0] mem [0:DEPTH-1];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              wb_we;
  logic [NUM_RD*DATA_W-1:0] rd_all;

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // Writes land only in RUN and lose to a simultaneous clear request.
  assign wb_we = bus.wr_en && ready && !bus.clr_req &&
                 !(HAS_Z && (bus.wr_addr == ZADDR));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wb_we) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rval;

    assign raddr = bus.rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rval = mem[raddr];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && ready && (bus.wr_addr == raddr)) begin
        rval = bus.wr_data;
      end
`endif
      if (HAS_Z && (raddr == ZADDR)) begin
        rval = '0;
      end
      if (!ready) begin
        rval = '0;
      end
    end

    assign rd_all[k*DATA_W +: DATA_W] = rval;
  end

  assign bus.rd_data = rd_all;
  assign bus.ready   = ready;

endmodule
